// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared serial bus frame constants and receiver state type
package bus_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 64;
  localparam int CRC_W   = 4;
  localparam int EOF_LEN = 2;
  localparam int CNT_W   = 7;

  localparam logic              FRAME_SOF  = 1'b0;
  localparam logic [CRC_W-1:0]  CRC_POLY   = 4'b0011;
  localparam logic [ADDR_W-1:0] BCAST_ADDR = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_EOF,
    ST_RESYNC
  } rx_state_t;

endpackage

// File: rtl/crc4_serial.sv
// rtl/crc4_serial.sv - bit-serial CRC-4 (x^4+x+1), MSB-first, init 0
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             data_bit,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ data_bit;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/bus_frame_receiver.sv
// rtl/bus_frame_receiver.sv - serial frame deserialiser with CRC-4 check,
// address filter and a valid/ready holding register
module bus_frame_receiver #(
  parameter int                ADDR_W     = bus_pkg::ADDR_W,
  parameter int                DATA_W     = bus_pkg::DATA_W,
  parameter int                CRC_W      = bus_pkg::CRC_W,
  parameter logic [ADDR_W-1:0] NODE_ADDR  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] BCAST_ADDR = bus_pkg::BCAST_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_in,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              crc_err,
  output logic              frame_err,
  output logic              overrun
);

  import bus_pkg::rx_state_t, bus_pkg::ST_IDLE, bus_pkg::ST_ADDR, bus_pkg::ST_DATA;
  import bus_pkg::ST_CRC, bus_pkg::ST_EOF, bus_pkg::ST_RESYNC, bus_pkg::FRAME_SOF;

  localparam int CNT_W = bus_pkg::CNT_W;
  localparam int SR_W  = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(bus_pkg::EOF_LEN - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  shift_q;
  logic [CRC_W-1:0] rx_crc_q;
  logic [CRC_W-1:0] crc_calc;

  logic crc_clear, crc_en, crc_shift;
  logic frame_done, eof_bad, crc_ok, addr_hit, accept, load;

  crc4_serial u_crc (
    .clock    (clock),
    .reset    (reset),
    .clear    (crc_clear),
    .en       (crc_en),
    .data_bit (bus_in),
    .crc      (crc_calc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus_in == FRAME_SOF) state_d = ST_ADDR;
      ST_ADDR:   if (cnt_q == ADDR_LAST) state_d = ST_DATA;
      ST_DATA:   if (cnt_q == DATA_LAST) state_d = ST_CRC;
      ST_CRC:    if (cnt_q == CRC_LAST) state_d = ST_EOF;
      ST_EOF: begin
        if (!bus_in) state_d = ST_RESYNC;
        else if (cnt_q == EOF_LAST) state_d = ST_IDLE;
      end
      ST_RESYNC: if (bus_in) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    crc_clear  = (state_q == ST_IDLE);
    crc_en     = (state_q == ST_ADDR) || (state_q == ST_DATA);
    crc_shift  = (state_q == ST_CRC);
    eof_bad    = (state_q == ST_EOF) && !bus_in;
    frame_done = (state_q == ST_EOF) && bus_in && (cnt_q == EOF_LAST);
  end

  // Completion decision is taken while the second EOF bit is on the line.
  assign crc_ok   = (crc_calc == rx_crc_q);
  assign addr_hit = (shift_q[SR_W-1 -: ADDR_W] == NODE_ADDR) ||
                    (shift_q[SR_W-1 -: ADDR_W] == BCAST_ADDR);
  assign accept   = frame_done && crc_ok && addr_hit;
  assign load     = accept && (!rx_valid || rx_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      rx_crc_q  <= '0;
      rx_valid  <= 1'b0;
      rx_addr   <= '0;
      rx_data   <= '0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Counter restarts on every field boundary and idles at zero.
      if (state_q == ST_IDLE || state_q == ST_RESYNC || state_d != state_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (crc_en) shift_q <= {shift_q[SR_W-2:0], bus_in};
      if (crc_shift) rx_crc_q <= {rx_crc_q[CRC_W-2:0], bus_in};

      crc_err   <= frame_done && !crc_ok;
      frame_err <= eof_bad;
      overrun   <= accept && rx_valid && !rx_ready;

      if (load) begin
        rx_valid <= 1'b1;
        rx_addr  <= shift_q[SR_W-1 -: ADDR_W];
        rx_data  <= shift_q[DATA_W-1:0];
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_frame_receiver.sv
// tb/tb_bus_frame_receiver.sv - self-checking bench for bus_frame_receiver
module tb_bus_frame_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_in;
  logic        rx_ready;
  logic        rx_valid;
  logic [3:0]  rx_addr;
  logic [63:0] rx_data;
  logic        busy, crc_err, frame_err, overrun;

  bus_frame_receiver dut (
    .clock     (clock),
    .reset     (reset),
    .bus_in    (bus_in),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .busy      (busy),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  bit tx_q[$];
  bit rdy_q[$];
  bit rst_q[$];

  logic        obs_valid[$];
  logic [3:0]  obs_addr[$];
  logic [63:0] obs_data[$];
  logic        obs_busy[$];
  logic        obs_crc[$];
  logic        obs_frm[$];
  logic        obs_ovr[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of (ADDR,DATA)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [3:0] a, input logic [63:0] d);
    logic [71:0] v;
    v = {a, d, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    end
    return v[3:0];
  endfunction

  task automatic push_bit(input bit b, input bit r, input bit rs = 1'b0);
    tx_q.push_back(b);
    rdy_q.push_back(r);
    rst_q.push_back(rs);
  endtask

  task automatic push_frame(input logic [3:0] a, input logic [63:0] d, input logic [3:0] c,
                            input bit e0, input bit e1, input bit r);
    push_bit(1'b0, r);
    for (int i = 3; i >= 0; i--) push_bit(a[i], r);
    for (int i = 63; i >= 0; i--) push_bit(d[i], r);
    for (int i = 3; i >= 0; i--) push_bit(c[i], r);
    push_bit(e0, r);
    push_bit(e1, r);
  endtask

  task automatic sample();
    int n;
    n = obs_crc.size();
    check("pulse_onehot", 64'($countones({crc_err, frame_err, overrun}) <= 1), 64'(1));
    if (n > 0) begin
      check("pulse_len", 64'({obs_crc[n-1] & crc_err, obs_frm[n-1] & frame_err,
                              obs_ovr[n-1] & overrun}), 64'(0));
    end
    obs_valid.push_back(rx_valid);
    obs_addr.push_back(rx_addr);
    obs_data.push_back(rx_data);
    obs_busy.push_back(busy);
    obs_crc.push_back(crc_err);
    obs_frm.push_back(frame_err);
    obs_ovr.push_back(overrun);
  endtask

  // Observation k is taken just before bit k is driven, i.e. it shows the
  // state after the edge that sampled bit k-1.
  task automatic run();
    obs_valid.delete(); obs_addr.delete(); obs_data.delete(); obs_busy.delete();
    obs_crc.delete(); obs_frm.delete(); obs_ovr.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clock);
      sample();
      bus_in   = tx_q[i];
      rx_ready = rdy_q[i];
      reset    = rst_q[i];
    end
    @(negedge clock);
    sample();
    bus_in   = 1'b1;
    rx_ready = 1'b0;
    reset    = 1'b0;
    tx_q.delete(); rdy_q.delete(); rst_q.delete();
  endtask

  task automatic count_pulses(output int nc, output int nf, output int no);
    nc = 0; nf = 0; no = 0;
    for (int i = 0; i < obs_crc.size(); i++) begin
      nc += int'(obs_crc[i]);
      nf += int'(obs_frm[i]);
      no += int'(obs_ovr[i]);
    end
  endtask

  initial begin
    int nc, nf, no, nlow;
    logic [63:0] d;
    logic [3:0]  a, c;
    bit          r, good, hit, pre, load, ev;
    logic        mv;
    logic [3:0]  ma;
    logic [63:0] md;

    reset = 1'b1; bus_in = 1'b0; rx_ready = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_valid", 64'(rx_valid), 64'(0));
    check("rst_addr", 64'(rx_addr), 64'(0));
    check("rst_data", rx_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pulses", 64'({crc_err, frame_err, overrun}), 64'(0));
    reset = 1'b0; bus_in = 1'b1;
    repeat (2) @(negedge clock);

    // Good frame to self, consumer always ready.
    push_frame(4'h1, 64'h0, 4'b0101, 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s1_idle_busy", 64'(obs_busy[0]), 64'(0));
    check("s1_mid_busy", 64'(obs_busy[40]), 64'(1));
    check("s1_not_early", 64'(obs_valid[74]), 64'(0));
    check("s1_valid", 64'(obs_valid[75]), 64'(1));
    check("s1_addr", 64'(obs_addr[75]), 64'(1));
    check("s1_data", obs_data[75], 64'(0));
    check("s1_consumed", 64'(obs_valid[76]), 64'(0));
    count_pulses(nc, nf, no);
    check("s1_no_pulses", 64'(nc + nf + no), 64'(0));

    // CRC mismatch, then the same frame with the right CRC.
    push_frame(4'h1, 64'h1, 4'b0101, 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    push_frame(4'h1, 64'h1, 4'b0110, 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s2_crc_err", 64'(obs_crc[75]), 64'(1));
    check("s2_no_valid", 64'(obs_valid[75]), 64'(0));
    count_pulses(nc, nf, no);
    check("s2_crc_count", 64'(nc), 64'(1));
    check("s2_good_valid", 64'(obs_valid[152]), 64'(1));
    check("s2_good_data", obs_data[152], 64'h1);

    // Address filter: foreign address ignored, broadcast accepted.
    d = {$urandom, $urandom};
    push_frame(4'h2, d, crc_ref(4'h2, d), 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    push_frame(4'hF, 64'h1, crc_ref(4'hF, 64'h1), 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s3_foreign_valid", 64'(obs_valid[75]), 64'(0));
    count_pulses(nc, nf, no);
    check("s3_no_pulses", 64'(nc + nf + no), 64'(0));
    check("s3_bcast_valid", 64'(obs_valid[152]), 64'(1));
    check("s3_bcast_addr", 64'(obs_addr[152]), 64'hF);
    check("s3_bcast_data", obs_data[152], 64'h1);

    // Back-to-back frames into a full holding register.
    push_frame(4'h1, 64'h1, crc_ref(4'h1, 64'h1), 1, 1, 0);
    push_frame(4'h1, 64'h0, crc_ref(4'h1, 64'h0), 1, 1, 0);
    push_bit(1, 0); push_bit(1, 0);
    run();
    check("s4_first_held", obs_data[75], 64'h1);
    check("s4_overrun", 64'(obs_ovr[150]), 64'(1));
    check("s4_still_valid", 64'(obs_valid[150]), 64'(1));
    check("s4_kept_data", obs_data[150], 64'h1);
    check("s4_overrun_off", 64'(obs_ovr[151]), 64'(0));

    // Same, with a consume on the completion cycle of the second frame.
    push_bit(1, 1);
    push_frame(4'h1, 64'h1, crc_ref(4'h1, 64'h1), 1, 1, 0);
    push_frame(4'h1, 64'h0, crc_ref(4'h1, 64'h0), 1, 1, 0);
    rdy_q[150] = 1'b1;
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s5_drained", 64'(obs_valid[1]), 64'(0));
    check("s5_first_data", obs_data[76], 64'h1);
    check("s5_swap_valid", 64'(obs_valid[151]), 64'(1));
    check("s5_swap_data", obs_data[151], 64'h0);
    check("s5_swap_no_ovr", 64'(obs_ovr[151]), 64'(0));
    check("s5_final_empty", 64'(obs_valid[153]), 64'(0));

    // Bad first EOF bit, then the line stuck low for 10 more clocks.
    push_frame(4'h1, 64'h0, 4'b0101, 0, 0, 1);
    repeat (9) push_bit(0, 1);
    repeat (3) push_bit(1, 1);
    push_frame(4'h1, 64'h0, 4'b0101, 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s6_frame_err", 64'(obs_frm[74]), 64'(1));
    count_pulses(nc, nf, no);
    check("s6_frm_count", 64'(nf), 64'(1));
    check("s6_other_pulses", 64'(nc + no), 64'(0));
    nlow = 0;
    for (int i = 75; i <= 84; i++) if (!obs_busy[i]) nlow++;
    check("s6_resync_hold", 64'(nlow), 64'(0));
    check("s6_back_idle", 64'(obs_busy[85]), 64'(0));
    check("s6_no_false_sof", 64'(obs_busy[86]), 64'(0));
    check("s6_recover", 64'(obs_valid[162]), 64'(1));

    // Reset asserted at DATA bit 30, then a clean frame.
    d = {$urandom, $urandom};
    push_frame(4'h1, 64'hFFFF_0000_FFFF_0000, 4'h0, 1, 1, 1);
    while (tx_q.size() > 35) begin
      void'(tx_q.pop_back()); void'(rdy_q.pop_back()); void'(rst_q.pop_back());
    end
    push_bit(0, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    push_frame(4'h1, d, crc_ref(4'h1, d), 1, 1, 1);
    push_bit(1, 1); push_bit(1, 1);
    run();
    check("s7_aborted", 64'(obs_busy[36]), 64'(0));
    count_pulses(nc, nf, no);
    check("s7_no_pulses", 64'(nc + nf + no), 64'(0));
    check("s7_valid", 64'(obs_valid[113]), 64'(1));
    check("s7_addr", 64'(obs_addr[113]), 64'(1));
    check("s7_data", obs_data[113], d);
    check("s7_consumed", 64'(obs_valid[114]), 64'(0));

    // Randomized frames against the holding-register model.
    mv = 1'b0; ma = '0; md = '0;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       a = 4'h1;
        1:       a = 4'hF;
        default: a = 4'($urandom_range(0, 15));
      endcase
      d = {$urandom, $urandom};
      c = crc_ref(a, d);
      if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
      r = ($urandom_range(0, 2) == 0);
      push_frame(a, d, c, 1, 1, r);
      push_bit(1, r); push_bit(1, r);
      run();

      good = (c == crc_ref(a, d));
      hit  = (a == 4'h1) || (a == 4'hF);
      pre  = mv && !r;
      load = good && hit && !pre;
      if (load) begin
        ma = a;
        md = d;
      end
      ev = load || pre;
      check("rnd_valid", 64'(obs_valid[75]), 64'(ev));
      check("rnd_crc_err", 64'(obs_crc[75]), 64'(!good));
      check("rnd_overrun", 64'(obs_ovr[75]), 64'(good && hit && pre));
      check("rnd_frame_err", 64'(obs_frm[75]), 64'(0));
      if (ev) begin
        check("rnd_addr", 64'(obs_addr[75]), 64'(ma));
        check("rnd_data", obs_data[75], md);
      end
      check("rnd_after", 64'(obs_valid[77]), 64'(ev && !r));
      mv = ev && !r;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_frame_receiver.md
Name: bus_frame_receiver

Overview:
- Downstream stage of the 16-node serial bus transmitter; samples the one-bit serial line driven onto bus_out, one bit per clock.
- Deserialises each frame and checks its CRC-4.
- Filters frames on receiver address.
- Presents accepted payloads on a valid/ready output register to the local node logic.

Parameters:
- NODE_ADDR, 4'd1, address this receiver accepts.
- BCAST_ADDR, 4'hF, broadcast address, also accepted.
- DATA_W, 64, payload width.
- ADDR_W, 4, receiver-address field width.
- CRC_W, 4, CRC field width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  1  serial line; idle level 1; connected to transmitter bus_out.
- rx_valid  out  1  accepted frame held on rx_addr/rx_data.
- rx_ready  in  1  consumer takes the frame when rx_valid && rx_ready.
- rx_addr  out  ADDR_W  receiver address of the held frame.
- rx_data  out  DATA_W  payload of the held frame.
- busy  out  1  high while a frame is being received (state != IDLE).
- crc_err  out  1  one-cycle pulse: frame dropped on CRC mismatch.
- frame_err  out  1  one-cycle pulse: frame dropped on bad EOF.
- overrun  out  1  one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- Frame format, MSB first, one bit per clock:
  - SOF: one 0.
  - ADDR: 4 bits.
  - DATA: 64 bits.
  - CRC: 4 bits.
  - EOF: two 1s.
  - Total length: 75 bits.
- Reset: all outputs are 0, rx_addr/rx_data are 0, state is IDLE, and bit counter and CRC register are 0. Reset mid-frame aborts the frame with no error pulse.
- State machine: IDLE, ADDR, DATA, CRC, EOF, RESYNC.
  - IDLE: bus_in==0 gives ADDR; clear CRC register and bit counter.
  - ADDR: shift 4 bits into the shift register and CRC, then go to DATA.
  - DATA: shift 64 bits into the shift register and CRC, then go to CRC. The counter is 7 bits and wraps to 0 at each state change.
  - CRC: shift 4 bits into the received-CRC register only, then go to EOF.
  - EOF: sample 2 bits.
    - A sampled 0 pulses frame_err and goes to RESYNC.
    - After the second 1, run the completion check and go to IDLE.
  - RESYNC: wait for bus_in==1, then go to IDLE. This prevents a stuck-low line from being seen as back-to-back SOFs.
- CRC definition:
  - Polynomial x^4+x+1, init 0, computed over ADDR then DATA (68 bits).
  - Per bit: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
- Completion check, evaluated on the clock that samples the second EOF bit:
  - Computed CRC != received CRC: pulse crc_err, drop the frame.
  - Otherwise, ADDR not NODE_ADDR and not BCAST_ADDR: drop silently, no pulse.
  - Otherwise, rx_valid=1 and rx_ready=0: pulse overrun, keep the old frame, drop the new one.
  - Otherwise, load rx_addr/rx_data and set rx_valid on the next edge. Latency is 1 clock after the last EOF bit.
- Handshake:
  - rx_valid stays high and rx_addr/rx_data are stable until a cycle with rx_ready=1.
  - rx_valid clears on that edge unless a new frame is loaded in the same cycle. Simultaneous consume and load gives rx_valid=1 with the new contents.
- Back-to-back frames: a SOF may follow the second EOF bit immediately. IDLE is entered on that edge, so a 0 on the next clock starts a new frame.
- Error pulses are mutually exclusive and last exactly one cycle.

Decomposition:
- Shared package (bus_pkg) holds:
  - FRAME_SOF, EOF_LEN, CRC_POLY=4'b0011.
  - Field widths ADDR_W/DATA_W/CRC_W.
  - BCAST_ADDR.
  - rx_state_t enum.
  - The transmitter uses the same constants.
- One natural sub-module: crc4_serial. Inputs: clock, reset, clear, en, bit. Output: crc[3:0]. The transmitter-side CRC generator reuses it.

Test Plan:
- Good frame to self: ADDR=4'h1, DATA=64'h0, CRC=4'b0101, rx_ready=1 → rx_valid for 1 cycle, 1 clock after the last EOF bit, with rx_addr=1, rx_data=0, and no error pulses.
- CRC mismatch: ADDR=1, DATA=64'h1, CRC=4'b0101 (correct value is 4'b0110) → crc_err pulses once, rx_valid stays 0. Repeat with CRC=4'b0110 → accepted, rx_data=64'h1.
- Address filter:
  - ADDR=4'h2, correct CRC → nothing happens.
  - ADDR=4'hF, DATA=64'h1, correct CRC (CRC-4 over the 68 bits, poly 4'b0011, init 0; the bench computes it with its reference model) → accepted with rx_addr=4'hF.
- Overrun and simultaneous consume, with rx_ready=0:
  - Two good back-to-back frames, DATA=1 then 64'h0 → first is held, overrun pulses at the end of the second, rx_data stays 1.
  - Repeat with rx_ready=1 only on the completion cycle of the second frame → rx_data=0, rx_valid=1.
- Framing: corrupt the first EOF bit to 0 and hold bus_in=0 for 10 clocks → frame_err pulses once, state stays in RESYNC and no SOF is detected until bus_in returns to 1.
- Reset mid-frame: assert reset at DATA bit 30 for 1 clock, then send a good frame → no pulses from the aborted frame, and the new frame is received correctly.
